mips_mem_responder: RTL and testbench

Memory-side responder for the multicycle MIPS core. It serves the word and byte requests issued by the main control FSM: LW/SW words, and LB/LBU bytes. It sits between the datapath's address/write-data registers and a word-organised unified instruction/data RAM. Requests use a valid/ready handshake with a configurable fixed latency, so slower memory can be modelled. Byte lanes are extracted big-endian, and the result is sign- or zero-extended according to the lb code.

---
 rtl/mips_mem_responder.sv | 155 +++++++++++++++
 tb/tb_mips_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module   : mips_mem_responder
// Brief    : Fixed-latency valid/ready memory responder for the multicycle MIPS
//            core; word and big-endian byte accesses to a word-organised RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  input  logic [1:0]  lb,
  output logic        rsp_valid,
  output logic [31:0] rd,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wd_q, wd_d;
  logic [1:0]      lb_q, lb_d;
  logic [31:0]     rd_q, rd_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   w_idx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic            w_err;
  logic            w_mem_we;

  assign w_idx  = adr_q[AW+1:2];
  assign w_word = mem[w_idx];

  // Big-endian lane select: byte offset 0 is the most significant byte.
  always_comb begin
    w_byte = w_word[7:0];
    case (adr_q[1:0])
      2'd0:    w_byte = w_word[31:24];
      2'd1:    w_byte = w_word[23:16];
      2'd2:    w_byte = w_word[15:8];
      default: w_byte = w_word[7:0];
    endcase
  end

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  assign w_err = (|adr_q[31:AW+2])
              || (lb_q == 2'b11)
              || ((lb_q == 2'b00) && (adr_q[1:0] != 2'b00))
              || (we_q && (lb_q != 2'b00));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wd_d     = wd_q;
    lb_d     = lb_q;
    rd_d     = rd_q;
    err_d    = err_q;
    w_mem_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = we;
          adr_d   = adr;
          wd_d    = wd;
          lb_d    = lb;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (w_err) begin
            err_d = 1'b1;
            rd_d  = '0;
          end else begin
            err_d = 1'b0;
            if (we_q) begin
              w_mem_we = 1'b1;
              rd_d     = wd_q;
            end else if (lb_q == 2'b00) begin
              rd_d = w_word;
            end else if (lb_q == 2'b01) begin
              rd_d = {24'b0, w_byte};
            end else begin
              rd_d = {{24{w_byte[7]}}, w_byte};
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      lb_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      lb_q    <= lb_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; a reset drops the state to IDLE so no pending write commits.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[w_idx] <= wd_q;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rd        = rd_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ============================================================================
// Module   : tb_mips_mem_responder
// Brief    : Self-checking bench for mips_mem_responder with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [1:0]  lb;
  logic        rsp_valid;
  logic [31:0] rd;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mdl [DEPTH];

  mips_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .we        (we),
    .adr       (adr),
    .wd        (wd),
    .lb        (lb),
    .rsp_valid (rsp_valid),
    .rd        (rd),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: returns expected {err, rd} and updates the model RAM.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] l, output logic e, output logic [31:0] r);
    int unsigned idx;
    int unsigned b;
    idx = a / 4;
    e = (idx >= DEPTH) || (l == 2'b11) || (l == 2'b00 && (a % 4) != 0) || (w && l != 2'b00);
    r = 32'h0;
    if (!e) begin
      if (w) begin
        mdl[idx] = d;
        r = d;
      end else if (l == 2'b00) begin
        r = mdl[idx];
      end else begin
        b = (mdl[idx] >> (8 * (3 - (a % 4)))) & 32'hFF;
        r = (l == 2'b10 && b >= 128) ? (b | 32'hFFFF_FF00) : b;
      end
    end
  endtask

  // One complete transaction starting from IDLE, sampled 1 time unit after edges.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] l);
    logic        e_exp;
    logic [31:0] r_exp;
    int          n;
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; we = w; adr = a; wd = d; lb = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
    we = $urandom; adr = $urandom; wd = $urandom; lb = 2'($urandom);
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (req_ready) chk("ready_while_busy", 32'd1, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    model(w, a, d, l, e_exp, r_exp);
    chk("latency", n, LATENCY);
    chk("rd", rd, r_exp);
    chk("err", {31'b0, err}, {31'b0, e_exp});
    @(posedge clk); #1;
    chk("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    chk("rd_hold", rd, r_exp);
  endtask

  initial begin
    int          acc;
    int          nrsp;
    int          rsp_t [4];
    logic [31:0] prior;
    logic        w;
    logic [1:0]  l;
    logic [31:0] a;

    reset = 1'b0; req_valid = 1'b0; we = 1'b0; adr = '0; wd = '0; lb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 2'b00);

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b00);
    xact(1'b0, 32'h10, 32'h0, 2'b00);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    xact(1'b0, 32'h13, 32'h0, 2'b01);
    chk("lbu_13", rd, 32'h0000_00EF);
    xact(1'b0, 32'h12, 32'h0, 2'b10);
    chk("lb_12", rd, 32'hFFFF_FFBE);
    xact(1'b0, 32'h10, 32'h0, 2'b10);
    chk("lb_10", rd, 32'hFFFF_FFDE);
    xact(1'b0, 32'h11, 32'h0, 2'b01);
    chk("lbu_11", rd, 32'h0000_00AD);

    xact(1'b0, 32'h12, 32'h0, 2'b00);               // misaligned LW
    xact(1'b1, 32'h14, 32'h1234_5678, 2'b01);       // byte-sized store is illegal
    xact(1'b0, 32'h14, 32'h0, 2'b00);
    xact(1'b0, 32'(DEPTH * 4), 32'h0, 2'b00);       // first out-of-range word
    xact(1'b0, 32'h10, 32'h0, 2'b11);
    xact(1'b0, 32'h10, 32'h0, 2'b00);
    chk("err_cleared", {31'b0, err}, 32'd0);

    // Back-to-back requests with req_valid held high throughout.
    req_valid = 1'b1; we = 1'b0; lb = 2'b00; adr = 32'h10;
    acc = 0; nrsp = 0;
    for (int t = 0; t < 14; t++) begin
      if (req_ready) begin
        if (acc == 2) req_valid = 1'b0;
        else begin
          adr = (acc == 0) ? 32'h10 : 32'h14;
          acc++;
        end
      end
      @(posedge clk); #1;
      if (rsp_valid) begin
        if (nrsp < 2) chk("b2b_rd", rd, (nrsp == 0) ? mdl[4] : mdl[5]);
        if (nrsp < 4) rsp_t[nrsp] = t;
        nrsp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", nrsp, 2);
    // Response, idle cycle, then LATENCY cycles of the next access.
    if (nrsp >= 2) chk("b2b_spacing", rsp_t[1] - rsp_t[0], LATENCY + 2);

    for (int i = 0; i < 150; i++) begin
      w = ($urandom_range(0, 3) == 0);
      l = 2'($urandom_range(0, 9) < 7 ? $urandom_range(1, 2) : $urandom_range(0, 3));
      if (w && $urandom_range(0, 3) != 0) l = 2'b00;
      a = $urandom_range(0, DEPTH * 4 + 15);
      if (l == 2'b00 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      xact(w, a, $urandom, l);
    end

    // Reset during WAIT must abandon the write.
    xact(1'b1, 32'h20, 32'h1122_3344, 2'b00);
    prior = mdl[8];
    req_valid = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'hCAFE_F00D; lb = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("midrst_rsp", {31'b0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_rsp_held", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_rd", rd, 32'd0);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    xact(1'b0, 32'h20, 32'h0, 2'b00);
    chk("midrst_prior", rd, prior);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
